// File: rtl/intr_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller.
// Holds the FSM state encoding and the line-index width function.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Width of a line index; a single-line build still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bundle between peripherals/control unit and the interrupt controller.
// The master side is the system; the slave side is intr_ctrl itself.
interface intr_ctrl_if
  import intr_pkg::*;
#(
  parameter int N_IRQ  = 4,
  parameter int ADDR_W = 10,
  parameter int ID_W   = id_width(N_IRQ)
);

  logic [N_IRQ-1:0]  irq;
  logic              we_mask;
  logic [N_IRQ-1:0]  mask_in;
  logic              s_finish_interr;
  logic              s_interruption;
  logic [ADDR_W-1:0] dir_interr;
  logic              in_service;
  logic [ID_W-1:0]   active_id;

  modport master (
    output irq, we_mask, mask_in, s_finish_interr,
    input  s_interruption, dir_interr, in_service, active_id
  );

  modport slave (
    input  irq, we_mask, mask_in, s_finish_interr,
    output s_interruption, dir_interr, in_service, active_id
  );

endinterface

// File: rtl/intr_ctrl_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
// Outputs idx = 0 when no bit is set; callers qualify it with any.
module intr_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    eligible,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = |eligible;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched, masked, fixed-priority request to the control unit.
// Optional build macro INTR_SYNC_EN adds a 2-flop synchronizer on every irq line.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int          N_IRQ      = 4,
  parameter int          ADDR_W     = 10,
  parameter int unsigned VEC_BASE   = 'h3C0,
  parameter int unsigned VEC_STRIDE = 16
) (
  input logic        clk,
  input logic        reset,
  intr_ctrl_if.slave bus
);

  localparam int ID_W = id_width(N_IRQ);
  localparam logic [N_IRQ-1:0] ONE_HOT0 = N_IRQ'(1);

  state_t            state_q, state_n;
  logic [N_IRQ-1:0]  irq_s, irq_q, rise;
  logic [N_IRQ-1:0]  pending, mask, eligible, clr_vec;
  logic [ID_W-1:0]   active_id, win_idx;
  logic              win_any, load_id, clr_pend;
  logic              busy;
  logic [ADDR_W-1:0] vec_addr;

`ifdef INTR_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.irq;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = bus.irq;
`endif

  assign rise     = irq_s & ~irq_q;
  assign eligible = pending & mask;
  assign clr_vec  = clr_pend ? (ONE_HOT0 << active_id) : '0;

  intr_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio (
    .eligible (eligible),
    .any      (win_any),
    .idx      (win_idx)
  );

  // Set is applied after clear so a fresh edge on the served line is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q     <= '0;
      pending   <= '0;
      mask      <= '1;
      active_id <= '0;
    end else begin
      irq_q   <= irq_s;
      pending <= (pending & ~clr_vec) | rise;
      if (bus.we_mask) mask <= bus.mask_in;
      if (load_id) active_id <= win_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    load_id  = 1'b0;
    clr_pend = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_n = REQUEST;
          load_id = 1'b1;
        end
      end
      REQUEST: begin
        state_n  = SERVICE;
        clr_pend = 1'b1;
      end
      SERVICE: begin
        if (bus.s_finish_interr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Vector arithmetic wraps at ADDR_W bits by construction.
  assign vec_addr = ADDR_W'(VEC_BASE) + ADDR_W'(VEC_STRIDE) * ADDR_W'(active_id);
  assign busy     = (state_q == REQUEST) || (state_q == SERVICE);

  assign bus.s_interruption = (state_q == REQUEST);
  assign bus.in_service     = busy;
  assign bus.dir_interr     = busy ? vec_addr : '0;
  assign bus.active_id      = active_id;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed scenarios plus random traffic vs a behavioural model.
// The stimulus side predicts each request; a negedge monitor pops and compares.
module tb_intr_ctrl;

  localparam int N          = 4;
  localparam int AW         = 10;
  localparam int VEC_BASE   = 'h3C0;
  localparam int VEC_STRIDE = 16;

  typedef struct {
    int id;
    int addr;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tb_cycle = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Behavioural model: line levels seen last edge, pending set, mask, service phase.
  bit [N-1:0] m_irq_prev;
  bit [N-1:0] m_pend;
  bit [N-1:0] m_mask;
  int         m_phase;
  int         m_cur;
  exp_t       exp_q[$];
  exp_t       mon_e;

  intr_ctrl_if #(.N_IRQ(N), .ADDR_W(AW)) bus ();

  intr_ctrl #(
    .N_IRQ      (N),
    .ADDR_W     (AW),
    .VEC_BASE   (VEC_BASE),
    .VEC_STRIDE (VEC_STRIDE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cycle <= tb_cycle + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, tb_cycle);
    end
  endtask

  function automatic int lowest_set(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_irq_prev = '0;
    m_pend     = '0;
    m_mask     = '1;
    m_phase    = 0;
    m_cur      = 0;
    exp_q.delete();
  endtask

  // Predict the effect of the next rising edge given the inputs about to be sampled.
  task automatic model_step(input bit [N-1:0] irq_v, input bit we, input bit [N-1:0] mask_v, input bit fin);
    bit [N-1:0] elig;
    bit [N-1:0] rise;
    exp_t       e;
    elig = m_pend & m_mask;
    rise = irq_v & ~m_irq_prev;
    if (m_phase == 0) begin
      if (elig != 0) begin
        m_cur   = lowest_set(elig);
        m_phase = 1;
        e.id    = m_cur;
        e.addr  = (VEC_BASE + m_cur * VEC_STRIDE) % (1 << AW);
        e.cyc   = tb_cycle + 1;
        exp_q.push_back(e);
      end
    end else if (m_phase == 1) begin
      m_pend[m_cur] = 1'b0;
      m_phase       = 2;
    end else if (fin) begin
      m_phase = 0;
    end
    m_pend     = m_pend | rise;
    if (we) m_mask = mask_v;
    m_irq_prev = irq_v;
  endtask

  task automatic apply_stimulus(input bit [N-1:0] irq_v, input bit we, input bit [N-1:0] mask_v, input bit fin);
    bus.irq             = irq_v;
    bus.we_mask         = we;
    bus.mask_in         = mask_v;
    bus.s_finish_interr = fin;
    model_step(irq_v, we, mask_v, fin);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus('0, 1'b0, '0, 1'b0);
  endtask

  task automatic finish_pulse();
    apply_stimulus('0, 1'b0, '0, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_output({tag, "_s_interruption"}, 32'(bus.s_interruption), 32'd0);
    check_output({tag, "_in_service"},     32'(bus.in_service),     32'd0);
    check_output({tag, "_dir_interr"},     32'(bus.dir_interr),     32'd0);
    check_output({tag, "_active_id"},      32'(bus.active_id),      32'd0);
  endtask

  // Monitor: compares every cycle and consumes a prediction whenever a request shows up.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check_output("in_service", 32'(bus.in_service), 32'(m_phase != 0));
      if (m_phase == 0) check_output("dir_idle", 32'(bus.dir_interr), 32'd0);
      if (bus.s_interruption === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_request actual=id%0d expected=none at cycle %0d", bus.active_id, tb_cycle);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("req_id",    32'(bus.active_id),  32'(mon_e.id));
          check_output("req_addr",  32'(bus.dir_interr), 32'(mon_e.addr));
          check_output("req_cycle", 32'(tb_cycle),       32'(mon_e.cyc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= tb_cycle) begin
        mon_e = exp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_request actual=none expected=id%0d at cycle %0d", mon_e.id, tb_cycle);
      end
    end
  end

  initial begin
    bit [N-1:0] irq_r;
    bit [N-1:0] flip;
    bus.irq             = '0;
    bus.we_mask         = 1'b0;
    bus.mask_in         = '0;
    bus.s_finish_interr = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("in_reset");
    reset = 1'b0;
    #1;
    check_outputs_zero("after_release");
    mon_en = 1'b1;
    idle(10);

    // Single line 2: expect 10'h3E0, service held until finish.
    apply_stimulus(4'b0100, 1'b0, '0, 1'b0);
    idle(4);
    finish_pulse();
    idle(2);

    // Lines 1 and 3 together: line 1 first, line 3 right after finish.
    apply_stimulus(4'b1010, 1'b0, '0, 1'b0);
    idle(4);
    finish_pulse();
    idle(4);
    finish_pulse();
    idle(2);

    // Masked line 0 stays pending until the mask is reopened.
    apply_stimulus(4'b0000, 1'b1, 4'b1110, 1'b0);
    apply_stimulus(4'b0001, 1'b0, '0, 1'b0);
    idle(5);
    apply_stimulus(4'b0000, 1'b1, 4'b1111, 1'b0);
    idle(3);
    finish_pulse();
    idle(2);

    // Re-pulse line 1 in service; finishes in IDLE and REQUEST are ignored.
    apply_stimulus(4'b0010, 1'b0, '0, 1'b0);
    idle(3);
    apply_stimulus(4'b0010, 1'b0, '0, 1'b0);
    idle(1);
    finish_pulse();
    finish_pulse();
    finish_pulse();
    idle(3);
    finish_pulse();
    idle(2);

    // Edge on the line being cleared: set wins, line served again.
    apply_stimulus(4'b0100, 1'b0, '0, 1'b0);
    apply_stimulus(4'b0000, 1'b0, '0, 1'b0);
    apply_stimulus(4'b0100, 1'b0, '0, 1'b0);
    idle(2);
    finish_pulse();
    idle(3);
    finish_pulse();
    idle(2);

    // Reset mid-service with line 2 pending: outputs drop at once, nothing follows.
    apply_stimulus(4'b0010, 1'b0, '0, 1'b0);
    idle(2);
    apply_stimulus(4'b0100, 1'b0, '0, 1'b0);
    idle(1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    idle(10);

    // Random traffic against the model.
    irq_r = '0;
    for (int c = 0; c < 400; c++) begin
      flip = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) flip[i] = 1'b1;
      irq_r = irq_r ^ flip;
      apply_stimulus(irq_r, ($urandom_range(15) == 0), N'($urandom_range(15)), ($urandom_range(3) == 0));
    end

    // Drain everything still pending.
    apply_stimulus('0, 1'b1, 4'b1111, 1'b1);
    for (int c = 0; c < 30; c++) apply_stimulus('0, 1'b0, '0, 1'b1);
    check_output("drained_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that drives the processor control unit's interrupt protocol. It latches rising edges on external interrupt lines and applies a per-line enable mask. It raises `s_interruption` for exactly one cycle, together with the vector address on `dir_interr`, then holds off further requests until the control unit signals `s_finish_interr`. It sits between the peripherals and the control unit, next to the program counter mux that consumes `dir_interr`.

## Interface
Parameters:
- `N_IRQ`, 4: number of interrupt lines, legal range 2..8.
- `ADDR_W`, 10: program address width.
- `VEC_BASE`, 10'h3C0: address of the handler for line 0.
- `VEC_STRIDE`, 16: address distance between consecutive handlers.

Ports:
- `clk` in 1: single clock. All state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `irq` in N_IRQ: interrupt request lines, level inputs, edge-detected internally.
- `we_mask` in 1: write strobe for the mask register.
- `mask_in` in N_IRQ: new mask value. A 1 enables the line.
- `s_finish_interr` in 1: from the control unit, end of handler.
- `s_interruption` out 1: to the control unit, one-cycle interrupt request.
- `dir_interr` out ADDR_W: handler address.
- `in_service` out 1: a handler is currently running.
- `active_id` out clog2(N_IRQ): index of the line being served.

## Operation
- Edge detect:
  - `irq_q` is a registered copy of `irq`.
  - A bit where `irq & ~irq_q` is 1 sets the matching bit in `pending`.
  - `pending` is set regardless of the mask.
- Eligible lines are `pending & mask`. The lowest index has the highest priority.
- FSM states are IDLE, REQUEST and SERVICE.
  - IDLE → REQUEST when the eligible vector is nonzero. The winning index is latched into `active_id`.
  - REQUEST → SERVICE unconditionally after one cycle. On this transition `pending[active_id]` is cleared.
  - SERVICE → IDLE on `s_finish_interr`.
- Outputs per state:
  - `s_interruption` = 1 only in REQUEST.
  - `in_service` = 1 in REQUEST and SERVICE.
  - `dir_interr` = (VEC_BASE + active_id*VEC_STRIDE) truncated to ADDR_W, held in REQUEST and SERVICE. It is 0 in IDLE.
- Nesting is not supported. New edges still accumulate in `pending` while in SERVICE.
- Boundary cases:
  - `s_finish_interr` in IDLE or REQUEST is ignored.
  - A new edge on the line being cleared in the same cycle: set wins, so the line stays pending.
  - A mask write during REQUEST or SERVICE does not cancel the committed request.
  - Masked pending bits remain pending and become eligible when unmasked.
  - When `we_mask` and an edge on the same line coincide, both take effect.
  - On leaving SERVICE, an eligible line enters REQUEST on the next edge. There is no idle gap beyond one IDLE cycle.
- Reset values:
  - FSM = IDLE.
  - `pending` = 0, `irq_q` = 0, `mask` = all ones, `active_id` = 0.
  - All outputs are 0.
  - A line already high when reset is released counts as one edge.
- Reset asserted mid-service returns the FSM to IDLE immediately and discards all pending bits.

## Timing
- The `irq` rising edge is first sampled at clock edge k: `pending` is set at k.
- At edge k+1 the FSM enters REQUEST. `s_interruption` and `dir_interr` are valid in cycle k+1..k+2.
- At edge k+2 the FSM enters SERVICE. Latency is 1 cycle from pending to request.
- `s_finish_interr` high at edge m: IDLE from m. A further eligible line gives REQUEST at m+1.
- A mask write takes effect at the edge where `we_mask` is sampled. Eligibility uses the registered mask.

## Configuration
- `INTR_SYNC_EN`:
  - When defined, each `irq` bit passes through a 2-flop synchronizer, reset to 0, before edge detection. This adds 2 cycles to the latency.
  - When undefined, `irq` is assumed synchronous to `clk` and feeds `irq_q` directly.

## Structure
- Package `intr_pkg` holds:
  - the state encoding constants IDLE=2'd0, REQUEST=2'd1, SERVICE=2'd2;
  - a function computing the ID width from N_IRQ.
- Sub-module `intr_prio_enc` is combinational. It takes the eligible vector and outputs `any` and `idx` with lowest-index priority.
- The top level holds the edge detect, `pending`, `mask`, FSM and vector arithmetic.

## Test plan
- Reset release with `irq`=0: all outputs 0, `mask`=4'b1111, state IDLE, no request for 10 cycles.
- Pulse `irq[2]` at edge k:
  - `s_interruption` high exactly one cycle after k+1;
  - `dir_interr`=10'h3E0 and `active_id`=2;
  - `in_service` stays high until `s_finish_interr`, then returns to 0.
- `irq[3]` and `irq[1]` rise on the same edge:
  - line 1 is served first (`dir_interr`=10'h3D0);
  - after `s_finish_interr`, line 3 (10'h3F0) is requested one cycle later.
- Mask line 0 (`mask_in`=4'b1110), pulse `irq[0]`:
  - no request;
  - write 4'b1111: request for line 0 on the next cycle.
- During SERVICE of line 1, re-pulse `irq[1]` and pulse `s_finish_interr` in IDLE:
  - the spurious finish is ignored;
  - line 1 is served a second time after the first finish.
- Assert `reset` mid-SERVICE with line 2 pending: outputs return to 0 asynchronously, and no request follows after release.
